// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with NZCV flags and valid/ready handshakes.
// Single-cycle ops retire in one cycle; MUL iterates shift-add over N cycles.
module alu_mc #(
  parameter int N      = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  acc;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [CW-1:0] cnt;

  logic op_and;
  logic op_or;
  logic op_add;
  logic op_sub;
  logic op_pass;
  logic op_mul;

  assign op_and  = (ALUControl == 4'b0000);
  assign op_or   = (ALUControl == 4'b0001);
  assign op_add  = (ALUControl == 4'b0010);
  assign op_sub  = (ALUControl == 4'b0110);
  assign op_pass = (ALUControl == 4'b0111);
  assign op_mul  = MUL_EN && (ALUControl == 4'b1000);

  logic [N:0] add_s;
  logic [N:0] sub_s;

  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};

  logic [N-1:0] s_res;
  logic         s_c;
  logic         s_v;

  // Single-cycle datapath; anything undecoded yields zero result and flags
  always_comb begin
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    unique case (1'b1)
      op_and:  s_res = a & b;
      op_or:   s_res = a | b;
      op_add: begin
        s_res = add_s[N-1:0];
        s_c   = add_s[N];
        s_v   = (a[N-1] == b[N-1]) &&
                (add_s[N-1] != a[N-1]);
      end
      op_sub: begin
        s_res = sub_s[N-1:0];
        s_c   = sub_s[N];
        s_v   = (a[N-1] != b[N-1]) &&
                (sub_s[N-1] != a[N-1]);
      end
      op_pass: s_res = b;
      default: s_res = '0;
    endcase
  end

  logic [N-1:0] acc_nx;

  // One shift-add step of the iterative multiplier
  always_comb begin
    acc_nx = acc;
    if (mplier[0]) acc_nx = acc + mcand;
  end

  // Control FSM with registered handshake, result and flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (op_mul) begin
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              result    <= s_res;
              zero      <= (s_res == '0);
              negative  <= s_res[N-1];
              carry     <= s_c;
              overflow  <= s_v;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + ONE;
          if (cnt == LAST) begin
            result    <= acc_nx;
            zero      <= (acc_nx == '0);
            negative  <= acc_nx[N-1];
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed checks of alu_mc
// against an arithmetic reference model.
module tb_alu_mc;

  typedef struct packed {
    logic [63:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        iv;
  logic        ordy;
  logic [63:0] ai;
  logic [63:0] bi;
  logic [3:0]  opc;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] result;
  logic        zero, negative, carry, overflow;

  logic        iv8, or8;
  logic [7:0]  a8, b8;
  logic [3:0]  op8;
  logic        ir8m, ov8m, z8m, n8m, c8m, v8m;
  logic        ir8n, ov8n, z8n, n8n, c8n, v8n;
  logic [7:0]  r8m, r8n;

  int npass = 0;
  int ntot  = 0;

  alu_mc #(.N(64), .MUL_EN(1'b1)) u64 (
    .clk(clk), .reset(rst_n),
    .in_valid(iv), .in_ready(in_ready),
    .a(ai), .b(bi), .ALUControl(opc),
    .out_valid(out_valid), .out_ready(ordy),
    .result(result), .zero(zero),
    .negative(negative), .carry(carry),
    .overflow(overflow)
  );

  alu_mc #(.N(8), .MUL_EN(1'b1)) u8m (
    .clk(clk), .reset(rst_n),
    .in_valid(iv8), .in_ready(ir8m),
    .a(a8), .b(b8), .ALUControl(op8),
    .out_valid(ov8m), .out_ready(or8),
    .result(r8m), .zero(z8m),
    .negative(n8m), .carry(c8m),
    .overflow(v8m)
  );

  alu_mc #(.N(8), .MUL_EN(1'b0)) u8n (
    .clk(clk), .reset(rst_n),
    .in_valid(iv8), .in_ready(ir8n),
    .a(a8), .b(b8), .ALUControl(op8),
    .out_valid(ov8n), .out_ready(or8),
    .result(r8n), .zero(z8n),
    .negative(n8n), .carry(c8n),
    .overflow(v8n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  function automatic exp_t model(input int w,
                                 input bit men,
                                 input logic [3:0] op,
                                 input logic [63:0] x,
                                 input logic [63:0] y);
    logic [63:0] mask, xm, ym;
    logic [64:0] wide;
    logic signed [129:0] sx, sy, s, lim;
    exp_t e;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm = x & mask;
    ym = y & mask;
    sx = $signed({66'd0, xm});
    sy = $signed({66'd0, ym});
    if (xm[w-1]) sx = sx - (130'sd1 <<< w);
    if (ym[w-1]) sy = sy - (130'sd1 <<< w);
    lim = 130'sd1 <<< (w - 1);
    e = '0;
    case (op)
      4'b0000: e.res = xm & ym;
      4'b0001: e.res = xm | ym;
      4'b0010: begin
        wide  = {1'b0, xm} + {1'b0, ym};
        e.res = wide[63:0] & mask;
        e.c   = wide[w];
        s     = sx + sy;
        e.v   = (s >= lim) || (s < -lim);
      end
      4'b0110: begin
        e.res = (xm - ym) & mask;
        e.c   = (xm >= ym);
        s     = sx - sy;
        e.v   = (s >= lim) || (s < -lim);
      end
      4'b0111: e.res = ym;
      4'b1000: e.res = men ? ((xm * ym) & mask) : 64'd0;
      default: e.res = 64'd0;
    endcase
    e.z = (e.res == 64'd0);
    e.n = e.res[w-1];
    return e;
  endfunction

  // Transaction-level reference for the 64-bit instance
  logic m_ov, m_ir;
  int   m_wait;
  exp_t m_e, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov   <= 1'b0;
      m_ir   <= 1'b1;
      m_wait <= 0;
      m_e    <= '0;
      m_pend <= '0;
    end else if (m_ir) begin
      if (iv) begin
        m_ir <= 1'b0;
        if (opc == 4'b1000) begin
          m_pend <= model(64, 1'b1, opc, ai, bi);
          m_wait <= 64;
        end else begin
          m_e  <= model(64, 1'b1, opc, ai, bi);
          m_ov <= 1'b1;
        end
      end
    end else if (m_wait != 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_e  <= m_pend;
        m_ov <= 1'b1;
      end
    end else if (m_ov && ordy) begin
      m_ov <= 1'b0;
      m_ir <= 1'b1;
    end
  end

  logic cmp_en = 1'b0;

  // Cycle-by-cycle comparison of the 64-bit instance
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("in_ready", 64'(in_ready), 64'(m_ir));
      if (m_ov) begin
        chk("result", result, m_e.res);
        chk("flags",
            {60'd0, zero, negative, carry, overflow},
            {60'd0, m_e.z, m_e.n, m_e.c, m_e.v});
      end
    end
  end

  function automatic logic [63:0] rnd64();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 6))
      0: r = 64'd0;
      1: r = '1;
      2: r = 64'h8000_0000_0000_0000;
      3: r = 64'h7FFF_FFFF_FFFF_FFFF;
      4: r = 64'($urandom_range(0, 20));
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] rndop();
    logic [3:0] o;
    o = 4'($urandom);
    case ($urandom_range(0, 7))
      0: o = 4'b0000;
      1: o = 4'b0001;
      2: o = 4'b0010;
      3: o = 4'b0110;
      4: o = 4'b0111;
      5: o = 4'b1000;
      default: ;
    endcase
    return o;
  endfunction

  task automatic run64(input logic [3:0] op,
                       input logic [63:0] x,
                       input logic [63:0] y,
                       input int hold,
                       output logic [63:0] r,
                       output logic [3:0] f,
                       output int lat);
    int k;
    @(negedge clk);
    iv = 1'b1; opc = op; ai = x; bi = y; ordy = 1'b0;
    k = 0;
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    iv = 1'b0; opc = 4'($urandom);
    ai = {$urandom, $urandom}; bi = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_timeout", 64'(out_valid), 64'd1);
    r = result;
    f = {zero, negative, carry, overflow};
    for (int h = 0; h < hold; h++) begin
      iv = 1'b1;
      @(negedge clk);
      chk("hold_result", result, r);
      chk("hold_flags", 64'({zero, negative, carry, overflow}),
          64'(f));
      chk("hold_ready", 64'(in_ready), 64'd0);
    end
    iv = 1'b0; ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic run8(input logic [3:0] op,
                      input logic [7:0] x,
                      input logic [7:0] y,
                      output logic [7:0] rm,
                      output logic [3:0] fm,
                      output int lm,
                      output logic [7:0] rn,
                      output logic [3:0] fn,
                      output int ln);
    int k;
    @(negedge clk);
    iv8 = 1'b1; op8 = op; a8 = x; b8 = y; or8 = 1'b0;
    k = 0;
    while (!(ir8m && ir8n) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk("accept8_timeout", 64'(ir8m & ir8n), 64'd1);
    @(negedge clk);
    iv8 = 1'b0; op8 = 4'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom);
    lm = 0; ln = 0; rm = '0; rn = '0; fm = '0; fn = '0;
    for (int c = 1; c <= 40; c++) begin
      if (ov8m && lm == 0) begin
        lm = c; rm = r8m; fm = {z8m, n8m, c8m, v8m};
      end
      if (ov8n && ln == 0) begin
        ln = c; rn = r8n; fn = {z8n, n8n, c8n, v8n};
      end
      if (lm != 0 && ln != 0) break;
      @(negedge clk);
    end
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk("drain8_valid", 64'({ov8m, ov8n}), 64'd0);
    chk("drain8_ready", 64'({ir8m, ir8n}), 64'd3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    logic [3:0]  f;
    int          lat;
    logic [7:0]  rm, rn;
    logic [3:0]  fm, fn;
    int          lm, ln;
    exp_t        e;
    logic [63:0] x, y;
    logic [3:0]  op;

    clk = 1'b0; rst_n = 1'b1;
    iv = 1'b0; ordy = 1'b0; ai = '0; bi = '0; opc = '0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", 64'({zero, negative, carry, overflow}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);
    cmp_en = 1'b1;

    run64(4'b0010, '1, 64'd1, 0, r, f, lat);
    chk("add_res", r, 64'd0);
    chk("add_flags", 64'(f), 64'(4'b1010));
    chk("add_lat", 64'(lat), 64'd1);

    run64(4'b0110, 64'h8000_0000_0000_0000, 64'd1, 0, r, f, lat);
    chk("sub1_res", r, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub1_flags", 64'(f), 64'(4'b0011));

    run64(4'b0110, 64'd3, 64'd5, 0, r, f, lat);
    chk("sub2_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub2_flags", 64'(f), 64'(4'b0100));

    run64(4'b1000, 64'd12345, 64'd6789, 10, r, f, lat);
    chk("mul_res", r, 64'd83810205);
    chk("mul_lat", 64'(lat), 64'd65);
    chk("mul_flags", 64'(f), 64'd0);

    run64(4'b0000, 64'hF0, 64'h3C, 0, r, f, lat);
    chk("and_res", r, 64'h30);
    run64(4'b0001, 64'hF0, 64'h3C, 0, r, f, lat);
    chk("or_res", r, 64'hFC);
    run64(4'b0111, 64'hF0, 64'h3C, 0, r, f, lat);
    chk("pass_res", r, 64'h3C);
    run64(4'b1111, 64'hF0, 64'h3C, 0, r, f, lat);
    chk("ill_res", r, 64'd0);
    chk("ill_flags", 64'(f), 64'(4'b1000));
    chk("ill_lat", 64'(lat), 64'd1);

    run64(4'b0110, 64'd3, 64'd5, 0, r, f, lat);
    @(negedge clk);
    iv = 1'b1; opc = 4'b1000;
    ai = 64'hFFFF; bi = 64'hFFFF;
    @(negedge clk);
    iv = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_mul_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_result", result, 64'd0);
    chk("async_flags", 64'({zero, negative, carry, overflow}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    run64(4'b0010, 64'd2, 64'd3, 0, r, f, lat);
    chk("post_rst_add", r, 64'd5);
    chk("post_rst_lat", 64'(lat), 64'd1);

    for (int i = 0; i < 50; i++) begin
      run64(rndop(), rnd64(), rnd64(),
            $urandom_range(0, 3), r, f, lat);
    end
    cmp_en = 1'b0;

    run8(4'b1000, 8'h10, 8'h11, rm, fm, lm, rn, fn, ln);
    chk("mul8_res", 64'(rm), 64'h10);
    chk("mul8_lat", 64'(lm), 64'd9);
    chk("noml_res", 64'(rn), 64'd0);
    chk("noml_flags", 64'(fn), 64'(4'b1000));
    chk("noml_lat", 64'(ln), 64'd1);

    for (int i = 0; i < 30; i++) begin
      op = rndop();
      x = 64'($urandom_range(0, 255));
      y = 64'($urandom_range(0, 255));
      run8(op, x[7:0], y[7:0], rm, fm, lm, rn, fn, ln);
      e = model(8, 1'b1, op, x, y);
      chk("r8m_res", 64'(rm), e.res);
      chk("r8m_flags", 64'(fm), 64'({e.z, e.n, e.c, e.v}));
      chk("r8m_lat", 64'(lm), (op == 4'b1000) ? 64'd9 : 64'd1);
      e = model(8, 1'b0, op, x, y);
      chk("r8n_res", 64'(rn), e.res);
      chk("r8n_flags", 64'(fn), 64'({e.z, e.n, e.c, e.v}));
      chk("r8n_lat", 64'(ln), 64'd1);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
